// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter timed by the shared oversample enable (OSR ticks per bit).
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry input FIFO; otherwise a single holding register.
module uart_transmitter #(
  parameter int OSR        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clken,
  input  logic       wr_en,
  input  logic [7:0] din,
  output logic       tx,
  output logic       busy,
  output logic       full
);

  localparam int CNT_W = (OSR > 1) ? $clog2(OSR) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_e;

  if (OSR < 2) begin : g_bad_osr
    $error("uart_transmitter: OSR must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_transmitter: FIFO_DEPTH must be a power of two, at least 2");
  end

  state_e           state_q;
  logic [CNT_W-1:0] tick_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             tx_q;

  logic             buf_empty;
  logic [7:0]       buf_head;
  logic             push;
  logic             pop;
  logic             last_tick;

  // full comes from registers only, so a write while full is dropped even on a popping edge.
  assign push      = wr_en && !full;
  assign pop       = (state_q == IDLE) && !buf_empty;
  assign last_tick = clken && (tick_q == CNT_W'(OSR - 1));

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;

  // NOTE: the storage array has no reset; count_q alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign buf_empty = (count_q == '0);
  assign buf_head  = mem_q[rd_ptr_q];
  assign full      = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
`else
  logic [7:0] hold_q;
  logic       valid_q;

  // push requires !valid_q and pop requires valid_q, so they never coincide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else if (push) begin
      hold_q  <= din;
      valid_q <= 1'b1;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end

  assign buf_empty = !valid_q;
  assign buf_head  = hold_q;
  assign full      = valid_q;
`endif

  // NOTE: tx_q is loaded with the level of the state being entered, so tx never glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= buf_head;
            tick_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (last_tick) begin
            tick_q  <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else if (clken) begin
            tick_q <= tick_q + 1'b1;
          end
        end
        DATA: begin
          if (last_tick) begin
            tick_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
              bit_q   <= bit_q + 3'd1;
            end
          end else if (clken) begin
            tick_q <= tick_q + 1'b1;
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (last_tick) begin
            tick_q  <= '0;
            state_q <= IDLE;
          end else if (clken) begin
            tick_q <= tick_q + 1'b1;
          end
        end
        default: begin
          tick_q  <= '0;
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE) || !buf_empty;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: a tx-line decoder pops expected bytes from a scoreboard.
// Honours UART_TX_FIFO_EN the same way as the design (overflow case in the FIFO build).
module tb_uart_transmitter;

  localparam int OSR = 16;
`ifdef UART_TX_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       clken;
  logic       wr_en;
  logic [7:0] din;
  logic       tx;
  logic       busy;
  logic       full;

  int n_checks  = 0;
  int n_pass    = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int clk_div   = 1;
  int frames_rx = 0;
  int n_pushed  = 0;

  logic [7:0] exp_q[$];
  int         starts[$];

  uart_transmitter #(
    .OSR       (OSR),
    .FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .clken(clken),
    .wr_en(wr_en),
    .din  (din),
    .tx   (tx),
    .busy (busy),
    .full (full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // clken changes just after a rising edge, one pulse every clk_div cycles.
  initial begin : clken_gen
    int div_cnt;
    div_cnt = 0;
    clken   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      clken   = (div_cnt == 0);
      div_cnt = (div_cnt + 1 >= clk_div) ? 0 : div_cnt + 1;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, input bit to_sb);
    int n;
    n = 0;
    while (full !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("write_room", full, 0);
    wr_en = 1'b1;
    din   = b;
    if (to_sb) begin
      exp_q.push_back(b);
      n_pushed++;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, busy, 0);
    repeat (2) @(negedge clk);
  endtask

  // Line decoder: samples mid-bit by counting clken pulses, abandons the frame on reset.
  initial begin : monitor
    logic [9:0] bits;
    bit         aborted;
    int         need;
    int         got;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        starts.push_back(cyc);
        aborted = 1'b0;
        bits    = '0;
        for (int k = 0; k < 10; k++) begin
          need = (k == 0) ? OSR / 2 : OSR;
          got  = 0;
          while (got < need && !aborted) begin
            @(posedge clk);
            if (rst !== 1'b1) aborted = 1'b1;
            else if (clken === 1'b1) got++;
          end
          if (!aborted) begin
            @(negedge clk);
            if (rst !== 1'b1) aborted = 1'b1;
            else bits[k] = tx;
          end
        end
        if (!aborted) begin
          frames_rx++;
          check("rx_start_bit", bits[0], 0);
          check("rx_stop_bit", bits[9], 1);
          check("rx_frame_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check("rx_byte", bits[8:1], exp_q.pop_front());
        end
      end
    end
  end

  initial begin : main
    logic [9:0] frm;
    int         busy_cnt;
    int         e_t[4];
    int         n_e;
    int         t_end;
    logic       prev;

    rst   = 1'b1;
    wr_en = 1'b0;
    din   = '0;
    #1 rst = 1'b0;
    #2;
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_full", full, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_tx", tx, 1);

    // Single byte 0xA5 with clken every cycle; t counts negedges after the storing edge.
    frm = {1'b1, 8'hA5, 1'b0};
    write_byte(8'hA5, 1'b1);
    check("a5_busy_t0", busy, 1);
    check("a5_tx_t0", tx, 1);
    check("a5_full_t0", full, 32'(!FIFO_EN));
    busy_cnt = 1;
    for (int t = 1; t <= 170; t++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (t == 1) check("a5_tx_fall", tx, 0);
      if (t >= 9 && t <= 153 && (t - 9) % 16 == 0)
        check($sformatf("a5_bit%0d", (t - 9) / 16), tx, 32'(frm[(t - 9) / 16]));
    end
    check("a5_busy_cycles", busy_cnt, 161);
    check("a5_busy_end", busy, 0);
    repeat (2) @(negedge clk);

    // Back-to-back: one stop bit plus one idle clock between frames.
    starts.delete();
    write_byte(8'h55, 1'b1);
    check("b2b_full_after_first", full, 32'(!FIFO_EN));
    write_byte(8'hAA, 1'b1);
    wait_idle("b2b", 600);
    check("b2b_start_count", starts.size(), 2);
    if (starts.size() == 2) check("b2b_start_gap", starts[1] - starts[0], 161);

    // Loopback through the decoder.
    write_byte(8'h3C, 1'b1);
    write_byte(8'h00, 1'b1);
    write_byte(8'hFF, 1'b1);
    wait_idle("loop", 800);

`ifdef UART_TX_FIFO_EN
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) check("ovf_full_at_sixth", full, 1);
      wr_en = 1'b1;
      din   = 8'(i);
      if (i < 6) begin
        exp_q.push_back(8'(i));
        n_pushed++;
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("ovf_full_after", full, 1);
    wait_idle("ovf", 6 * 161 + 50);
`else
    write_byte(8'h11, 1'b1);
    check("drop_full", full, 1);
    wr_en = 1'b1;
    din   = 8'h22;
    @(negedge clk);
    wr_en = 1'b0;
    check("drop_full_after_pop", full, 0);
    check("drop_busy", busy, 1);
    wait_idle("drop", 400);
`endif

    // Sparse clken: the pop edge is placed on a clken edge so the frame is exactly 640 clk.
    clk_div = 4;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8 && clken !== 1'b1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    write_byte(8'h81, 1'b1);
    for (int i = 0; i < 4; i++) e_t[i] = 0;
    n_e   = 0;
    t_end = 0;
    prev  = tx;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (tx !== prev) begin
        if (n_e < 4) e_t[n_e] = cyc;
        n_e++;
        prev = tx;
      end
      if (busy !== 1'b1) begin
        t_end = cyc;
        break;
      end
    end
    check("sparse_edges", n_e, 4);
    check("sparse_start_len", e_t[1] - e_t[0], 64);
    check("sparse_bit0_len", e_t[2] - e_t[1], 64);
    check("sparse_zero_run", e_t[3] - e_t[2], 384);
    check("sparse_frame_len", t_end - e_t[0], 640);
    clk_div = 1;
    repeat (4) @(negedge clk);

    // Reset during DATA bit 3 of 0xF0; that frame is never expected.
    write_byte(8'hF0, 1'b0);
    repeat (70) @(negedge clk);
    check("rst_mid_bit3", tx, 0);
    check("rst_mid_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("rst_async_tx", tx, 1);
    check("rst_async_busy", busy, 0);
    check("rst_async_full", full, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_release_tx", tx, 1);
    check("rst_release_busy", busy, 0);
    write_byte(8'h12, 1'b1);
    wait_idle("post_rst", 400);

    check("sb_empty", exp_q.size(), 0);
    check("frames_rx", frames_rx, n_pushed);
    check("final_tx", tx, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit side of the UART controller. Accepts bytes from the system side and sends 8N1 frames (1 start, 8 data LSB first, 1 stop) on `tx`. Bit timing uses the same 16x oversample enable `clken` that drives the receiver, so a transmitter and receiver fed from one baud generator interoperate directly. A small input buffer decouples the writer from frame timing.

## Interface
- `OSR`, 16: `clken` pulses per bit period; must match the receiver (16).
- `FIFO_DEPTH`, 4: buffer entries when `UART_TX_FIFO_EN` is defined; power of two, minimum 2.
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: one clock; reset is asynchronous and active-low.
- `clken` input 1: oversample tick, one-cycle pulse, OSR per bit.
- `wr_en` input 1: write strobe; `din` captured when `wr_en && !full`.
- `din` input 8: byte to send.
- `tx` output 1: serial line, idle high.
- `busy` output 1: high while a frame is in progress or any byte is buffered.
- `full` output 1: buffer cannot accept a write this cycle.

## Operation
- States: IDLE, START, DATA, STOP; 2-bit state register, other encodings go to IDLE.
- IDLE: `tx`=1. If buffer non-empty, pop head into the 8-bit shift register, clear the tick counter and bit index, go to START on that clock edge (independent of `clken`).
- START: `tx`=0. Tick counter increments on each `clken`; on the `clken` where counter == OSR-1, clear counter, go to DATA.
- DATA: `tx`=shift[0]. At counter == OSR-1: clear counter; if index == 7 go to STOP, else shift right, index+1.
- STOP: `tx`=1. At counter == OSR-1: go to IDLE.
- `tx` is registered; glitch-free.
- Writes when `full`=1 are dropped, no state change. `full` is evaluated before a same-cycle pop: write while full is dropped even if a pop occurs that edge.
- Write into an empty buffer while in IDLE: stored this edge, popped next edge.
- `clken` with no frame in progress has no effect.
- `busy` = (state != IDLE) || buffer non-empty; registered-equivalent, no combinational path from `wr_en`.

## Timing
- Reset (asserted): `tx`=1, `busy`=0, `full`=0, state IDLE, counters 0, buffer empty. Applies immediately, asynchronously; an in-flight frame is abandoned and `tx` goes high without a stop bit.
- Write-to-start latency from idle: `wr_en` edge N stores byte, edge N+1 enters START, `tx` falls after edge N+1.
- Frame length: exactly 10×OSR `clken` pulses; with `clken` every cycle, 160 clk.
- Back-to-back: if buffer non-empty at STOP exit, IDLE lasts one clk then next START; one stop bit plus one clk of extra idle-high.
- `busy` falls on the edge that enters IDLE with an empty buffer.

## Configuration
- `UART_TX_FIFO_EN` defined: buffer is a FIFO_DEPTH circular FIFO, read/write pointers wrap modulo FIFO_DEPTH, occupancy counter log2(FIFO_DEPTH)+1 bits; `full` when occupancy == FIFO_DEPTH.
- Not defined: buffer is a single holding register plus valid flag (double buffering with the shift register); `full` = valid. `FIFO_DEPTH` ignored.

## Test plan
- Single byte: `clken` every cycle, write 0xA5 from reset -> `tx` per 16-clk bit: 0,1,0,1,0,0,1,0,1,1; `busy` high 161 clk after write, then 0.
- Loopback: `tx` into the receiver sharing `clken`, send 0x3C, 0x00, 0xFF -> receiver `data_out` matches each with `rdy` pulse, no framing slip.
- Back-to-back: write 0x55 and 0xAA in consecutive cycles -> two frames separated by exactly one stop bit plus 1 clk idle; `full` never set (no-FIFO build sets `full` for the second byte until the first pop).
- Overflow (FIFO build, depth 4): write 0x01..0x06 on six consecutive cycles while idle -> 0x01 in shifter, 0x02..0x05 buffered, `full`=1 at sixth write, 0x06 dropped; exactly five frames sent.
- Sparse `clken` (every 4th clk): send 0x81 -> each bit lasts 64 clk, frame 640 clk, bit values unchanged.
- Reset mid-frame: assert `rst` low during DATA bit 3 of 0xF0 -> `tx`=1, `busy`=0, `full`=0 immediately; after release, write 0x12 transmits correctly with no residue.
